idli_serial_decode_m: RTL
=========================

# idli_serial_decode_m

Parametrised serial instruction decoder: deserialises 16b instruction words arriving LANES bits per beat over the SQI fetch path, extracts opcode and operand fields, optionally collects a trailing 16b immediate word, and presents each decoded op to issue through a valid/ready handshake. It sits between the SQI memory interface and issue. It generalises the fixed 4b-per-cycle decoder with a configurable lane width, immediate words, output backpressure, a one-entry output buffer and a flush.

## Interface
- LANES, 4: bits per beat; legal values 1, 2, 4. BEATS = 16/LANES.
- IMM_EN, 1: when 1, any instruction whose C field equals IMM_REG is followed by a 16b immediate word.
- IMM_REG, 3'd7: C-field value that marks a trailing immediate.
- i_sdc_gck  in  1  clock.
- i_sdc_rst  in  1  reset; asynchronous, active-high.
- i_sdc_enc  in  LANES  encoding beat, MSB-first within the instruction word.
- i_sdc_enc_vld  in  1  beat valid.
- o_sdc_enc_rdy  out  1  beat accepted when vld && rdy.
- i_sdc_flush  in  1  abort the partial instruction and drop any buffered op.
- o_sdc_op_vld  out  1  decoded op available.
- i_sdc_op_rdy  in  1  issue consumes op when vld && rdy.
- o_sdc_op  out  op_t  decoded fields a, b, c, p, q (idli_pkg op_t).
- o_sdc_opc  out  5  opcode bits [15:11].
- o_sdc_has_imm  out  1  op carries an immediate.
- o_sdc_imm  out  16  immediate word; 0 when has_imm=0.
- o_sdc_busy  out  1  instruction or immediate partially received.

## Operation
- Word layout of instruction w[15:0]: opc=w[15:11], p=w[10:9], a={w[8],w[7:6]}, q=w[7:6], b=w[5:3], c=w[2:0].
- P override: if w[15:12]==4'b0000 (NOP/BZ), p = PREG_PT regardless of w[10:9].
- States: INSTR (collecting instruction beats), IMM (collecting immediate beats). A beat counter (log2 BEATS bits) runs within each state.
- Each accepted beat shifts into a 16b shift register: sr <= {sr[15-LANES:0], i_sdc_enc}.
- INSTR final beat: if IMM_EN && assembled c==IMM_REG, latch decoded fields into a pending register and go to IMM; otherwise load the output register and stay in INSTR with counter 0.
- IMM final beat: load output register with pending fields, has_imm=1, imm=assembled word; go to INSTR.
- Output register is one entry. o_sdc_op_vld stays set until vld && rdy. Fields are held stable while vld && !rdy.
- o_sdc_enc_rdy = !(final beat of current phase that would load the output register) || !o_sdc_op_vld || i_sdc_op_rdy. Non-final beats are always accepted, so the next instruction pipelines behind a stalled op. Only the completing beat stalls.
- Completing beat with the output draining the same cycle (vld && rdy): the beat is accepted and new op_vld=1 the next cycle, giving back-to-back ops.
- i_sdc_flush: counter to 0, state to INSTR, pending and shift register don't-care, o_sdc_op_vld cleared next cycle. Flush wins over a same-cycle beat, which is dropped. o_sdc_enc_rdy stays 1 during flush.
- o_sdc_busy = counter!=0 || state==IMM.
- Beats are only consumed on vld && rdy. A gap of any length mid-instruction holds all state.

## Timing
- Reset (async assert, sync release inside the clock domain): state INSTR, counter 0, o_sdc_op_vld 0, o_sdc_has_imm 0, o_sdc_imm 0, o_sdc_opc 0, o_sdc_op all 0 with p=PREG_PT, o_sdc_busy 0, o_sdc_enc_rdy 1.
- Reset mid-instruction discards all partial state. The first beat after release is treated as beat 0.
- Latency: o_sdc_op_vld rises the cycle after the final accepted beat. Without an immediate that is BEATS accepted beats; with an immediate it is 2*BEATS.
- Throughput: one op per BEATS cycles (2*BEATS with immediate) with no bubbles when issue is always ready.

## Test plan
- LANES=4, beats C,1,2,3, op_rdy=1 -> next cycle vld=1, opc=5'h18, p=0, a=4, q=0, b=4, c=3, has_imm=0; busy high for cycles 1-3 only.
- LANES=4, word 0x0600 -> p=PREG_PT (override), opc=0; word 0x0000 -> p=PREG_PT.
- IMM_EN=1, word 0xC127 then 0xBEEF -> single op, c=7, has_imm=1, imm=16'hBEEF, vld 8 beats after start; IMM_EN=0 with the same stream -> two ops (0xC127, 0xBEEF).
- LANES=1 and LANES=2, word 0xC123 with random vld gaps -> identical fields to the LANES=4 case after 16 and 8 beats respectively.
- op_rdy=0 with two instructions streamed -> first op held stable, second accepts 3 beats then enc_rdy=0 on its 4th; raise op_rdy -> 4th beat accepted same cycle, second op vld next cycle.
- Flush after 2 beats, and flush while op_vld=1 -> busy=0 and op_vld=0 next cycle; the next 4 beats decode as a fresh instruction. Assert reset mid-immediate -> all outputs at reset values.

Source files
------------

// File: rtl/idli_serial_decode_m.sv
// Serial instruction decoder for the SQI fetch path.
// Instruction words arrive LANES bits per beat, MSB first. Each word is split
// into opcode and operand fields. An instruction may be followed by a 16b
// immediate word, which is collected before the op is handed to issue.
// A one-entry output register lets the next instruction stream in behind a
// stalled op.
`timescale 1ns/1ps

package idli_pkg;
    // Predicate register that always reads true. NOP/BZ encodings use it.
    localparam logic [1:0] PREG_PT = 2'd3;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic [1:0] p;
        logic [1:0] q;
    } op_t;

    typedef enum logic {
        SDC_INSTR = 1'b0,
        SDC_IMM   = 1'b1
    } sdc_state_e;
endpackage

module idli_serial_decode_m
    import idli_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter bit          IMM_EN  = 1'b1,
    parameter logic [2:0]  IMM_REG = 3'd7
) (
    input  logic             i_sdc_gck,
    input  logic             i_sdc_rst,
    input  logic [LANES-1:0] i_sdc_enc,
    input  logic             i_sdc_enc_vld,
    output logic             o_sdc_enc_rdy,
    input  logic             i_sdc_flush,
    output logic             o_sdc_op_vld,
    input  logic             i_sdc_op_rdy,
    output op_t              o_sdc_op,
    output logic [4:0]       o_sdc_opc,
    output logic             o_sdc_has_imm,
    output logic [15:0]      o_sdc_imm,
    output logic             o_sdc_busy,
    output sdc_state_e       o_sdc_state
);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high. Valid never depends on ready; once raised, the
    // op valid and its fields hold until the transfer (or a flush). Beat
    // ready only drops for the beat that would load a still-occupied output
    // register.

    localparam int unsigned    BEATS = 16 / LANES;
    localparam int unsigned    CW    = $clog2(BEATS);
    localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

    sdc_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15-LANES:0] sr_q;
    logic [15:0]     sr_next;
    op_t             pend_op;
    logic [4:0]      pend_opc;

    logic            last_beat;
    logic            wants_imm;
    logic            loads_out;
    logic            beat_acc;
    logic            ld_out;
    logic            ld_pend;

    // Field extraction; NOP/BZ (top nibble zero) always use the true predicate.
    function automatic op_t decode(input logic [15:0] w);
        op_t o;
        o.a = {w[8], w[7:6]};
        o.b = w[5:3];
        o.c = w[2:0];
        o.q = w[7:6];
        o.p = (w[15:12] == 4'b0000) ? PREG_PT : w[10:9];
        return o;
    endfunction

    // The word as it will look once the current beat is shifted in.
    assign sr_next   = {sr_q, i_sdc_enc};
    assign last_beat = (cnt_q == LAST);
    assign wants_imm = IMM_EN && (sr_next[2:0] == IMM_REG);
    // Only the completing beat that hands an op to the output register can stall.
    assign loads_out = last_beat && ((state_q == SDC_IMM) || !wants_imm);
    assign o_sdc_enc_rdy = i_sdc_flush || !loads_out || !o_sdc_op_vld || i_sdc_op_rdy;
    // Flush takes priority, so a beat presented alongside it is dropped.
    assign beat_acc  = i_sdc_enc_vld && o_sdc_enc_rdy && !i_sdc_flush;

    assign o_sdc_busy  = (cnt_q != '0) || (state_q == SDC_IMM);
    assign o_sdc_state = state_q;

    // Next-state logic: beat counting, phase changes and register load strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_out  = 1'b0;
        ld_pend = 1'b0;
        if (i_sdc_flush) begin
            state_d = SDC_INSTR;
            cnt_d   = '0;
        end else if (beat_acc) begin
            if (last_beat) begin
                cnt_d = '0;
                case (state_q)
                    SDC_INSTR: begin
                        if (wants_imm) begin
                            ld_pend = 1'b1;
                            state_d = SDC_IMM;
                        end else begin
                            ld_out = 1'b1;
                        end
                    end
                    SDC_IMM: begin
                        ld_out  = 1'b1;
                        state_d = SDC_INSTR;
                    end
                    default: state_d = SDC_INSTR;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Phase and beat counter registers.
    always_ff @(posedge i_sdc_gck or posedge i_sdc_rst) begin
        if (i_sdc_rst) begin
            state_q <= SDC_INSTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift register and pending fields; their contents are only meaningful
    // once the counter says so, so they carry no reset.
    always_ff @(posedge i_sdc_gck) begin
        if (beat_acc) begin
            sr_q <= sr_next[15-LANES:0];
        end
        if (ld_pend) begin
            pend_op  <= decode(sr_next);
            pend_opc <= sr_next[15:11];
        end
    end

    // One-entry output register presented to issue.
    always_ff @(posedge i_sdc_gck or posedge i_sdc_rst) begin
        if (i_sdc_rst) begin
            o_sdc_op_vld  <= 1'b0;
            o_sdc_op      <= '{a: 3'd0, b: 3'd0, c: 3'd0, p: PREG_PT, q: 2'd0};
            o_sdc_opc     <= 5'd0;
            o_sdc_has_imm <= 1'b0;
            o_sdc_imm     <= 16'd0;
        end else if (i_sdc_flush) begin
            o_sdc_op_vld <= 1'b0;
        end else if (ld_out) begin
            o_sdc_op_vld <= 1'b1;
            if (state_q == SDC_IMM) begin
                o_sdc_op      <= pend_op;
                o_sdc_opc     <= pend_opc;
                o_sdc_has_imm <= 1'b1;
                o_sdc_imm     <= sr_next;
            end else begin
                o_sdc_op      <= decode(sr_next);
                o_sdc_opc     <= sr_next[15:11];
                o_sdc_has_imm <= 1'b0;
                o_sdc_imm     <= 16'd0;
            end
        end else if (o_sdc_op_vld && i_sdc_op_rdy) begin
            o_sdc_op_vld <= 1'b0;
        end
    end

endmodule
